// File: rtl/shift_reg_pkg.sv
// Shared helpers for the elastic shift register: counter sizing and parameter sanity checks.
package shift_reg_pkg;

  // Bits needed to hold an occupancy value in 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // A pipeline needs at least one stage.
  function automatic bit stages_ok(input int unsigned n);
    return n >= 1;
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic pipeline slot: a data register plus its valid flag, loaded when ld_i is high.
module elastic_stage #(
  parameter int unsigned      WIDTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Next state: clear drops the valid but keeps data; otherwise load or hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (ld_i) begin
      data_d  = data_i;
      valid_d = valid_i;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= RESET_VALUE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/elastic_shift_register.sv
// Elastic register pipeline with ready/valid on both sides, bubble collapsing, flush and occupancy count.
module elastic_shift_register
  import shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH         = 3,
  parameter int unsigned      NUM_OF_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  localparam int unsigned     CW            = cnt_width(NUM_OF_STAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned N = NUM_OF_STAGES;

  if (!stages_ok(N)) begin : g_bad_depth
    $error("elastic_shift_register: NUM_OF_STAGES must be at least 1");
  end

  logic [N-1:0]     ld;
  logic [N-1:0]     v;
  logic [WIDTH-1:0] r [N];
  logic [CW-1:0]    count_q, count_d;
  logic             in_fire, out_fire;

  // Load-enable chain: a slot advances when it is empty or the slot ahead advances.
  always_comb begin
    ld        = '0;
    ld[N-1]   = ~v[N-1] | out_ready;
    for (int i = int'(N) - 2; i >= 0; i--) begin
      ld[i] = ~v[i] | ld[i+1];
    end
  end

  // Handshake outputs are forced quiet while reset is held or a flush is pending.
  assign in_ready  = reset & ld[0] & ~flush;
  assign out_valid = reset & v[N-1] & ~flush;
  assign out_data  = reset ? r[N-1] : RESET_VALUE;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Stage instances; stage 0 is fed from the input port, the rest from their predecessor.
  for (genvar i = 0; i < N; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
    if (i == 0) begin : g_head
      assign d_in = in_data;
      assign v_in = in_fire;
    end else begin : g_body
      assign d_in = r[i-1];
      assign v_in = v[i-1];
    end
    elastic_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk     (clk),
      .rst_n   (reset),
      .clr_i   (flush),
      .ld_i    (ld[i]),
      .data_i  (d_in),
      .valid_i (v_in),
      .data_o  (r[i]),
      .valid_o (v[i])
    );
  end

  // Occupancy next state: flush empties, otherwise track accepted minus delivered words.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_fire) - CW'(out_fire);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = reset ? count_q : '0;
  assign empty = ~reset | (count_q == '0);
  assign full  = reset & (count_q == CW'(N));

endmodule

// File: tb/tb_elastic_shift_register.sv
// Bench for elastic_shift_register: three configurations checked against a word-position model.
module tb_elastic_shift_register;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: N=2, WIDTH=3
  logic       iv0 = 1'b0, ordy0 = 1'b0, fl0 = 1'b0;
  logic [2:0] id0 = '0;
  logic       ir0, ov0, em0, fu0;
  logic [2:0] od0;
  logic [1:0] cnt0;
  // Instance 1: N=4, WIDTH=3
  logic       iv1 = 1'b0, ordy1 = 1'b0, fl1 = 1'b0;
  logic [2:0] id1 = '0;
  logic       ir1, ov1, em1, fu1;
  logic [2:0] od1;
  logic [2:0] cnt1;
  // Instance 2: N=1, WIDTH=8, RESET_VALUE=A5
  logic       iv2 = 1'b0, ordy2 = 1'b0, fl2 = 1'b0;
  logic [7:0] id2 = '0;
  logic       ir2, ov2, em2, fu2;
  logic [7:0] od2;
  logic [0:0] cnt2;

  elastic_shift_register #(.WIDTH(3), .NUM_OF_STAGES(2), .RESET_VALUE(3'd0)) u_n2 (
    .clk(clk), .reset(reset), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .count(cnt0), .empty(em0), .full(fu0));
  elastic_shift_register #(.WIDTH(3), .NUM_OF_STAGES(4), .RESET_VALUE(3'd0)) u_n4 (
    .clk(clk), .reset(reset), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .count(cnt1), .empty(em1), .full(fu1));
  elastic_shift_register #(.WIDTH(8), .NUM_OF_STAGES(1), .RESET_VALUE(8'hA5)) u_n1 (
    .clk(clk), .reset(reset), .flush(fl2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .count(cnt2), .empty(em2), .full(fu2));

  int nvec = 0;
  int nerr = 0;
  int rcv  = 0;

  // Model: per instance, words oldest-first with their data and the stage they sit in.
  int md [3][8];
  int mp [3][8];
  int mc [3];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one instance against the model, then advance the model across the coming edge.
  task automatic check_inst(input string nm, input int k, input int n, input int rstv,
                            input bit iv, input int id, input bit ordy, input bit fl,
                            input bit ov, input int od, input bit ir, input int cnt,
                            input bit em, input bit fu);
    bit ev, eir;
    int ecnt, m, lim;
    int np [8];
    int nd [8];
    if (!reset) begin
      chk({nm, "_rst_out_valid"}, int'(ov), 0);
      chk({nm, "_rst_out_data"}, od, rstv);
      chk({nm, "_rst_in_ready"}, int'(ir), 0);
      chk({nm, "_rst_empty"}, int'(em), 1);
      chk({nm, "_rst_full"}, int'(fu), 0);
      chk({nm, "_rst_count"}, cnt, 0);
      mc[k] = 0;
      return;
    end
    ecnt = mc[k];
    ev   = (ecnt > 0) && (mp[k][0] == n - 1) && !fl;
    chk({nm, "_out_valid"}, int'(ov), int'(ev));
    if (ev) chk({nm, "_out_data"}, od, md[k][0]);
    chk({nm, "_count"}, cnt, ecnt);
    chk({nm, "_empty"}, int'(em), int'(ecnt == 0));
    chk({nm, "_full"}, int'(fu), int'(ecnt == n));
    if (fl) begin
      chk({nm, "_in_ready"}, int'(ir), 0);
      mc[k] = 0;
      return;
    end
    m   = 0;
    lim = n;
    for (int j = (ev && ordy) ? 1 : 0; j < ecnt; j++) begin
      np[m] = (mp[k][j] + 1 < lim) ? mp[k][j] + 1 : mp[k][j];
      nd[m] = md[k][j];
      lim   = np[m];
      m++;
    end
    eir = (m == 0) ? 1'b1 : (np[m-1] > 0);
    chk({nm, "_in_ready"}, int'(ir), int'(eir));
    if (iv && eir) begin
      np[m] = 0;
      nd[m] = id;
      m++;
    end
    for (int j = 0; j < m; j++) begin
      mp[k][j] = np[j];
      md[k][j] = nd[j];
    end
    mc[k] = m;
  endtask

  // Per-cycle compare of every instance, plus in-order delivery scoreboard for the N=1 stream.
  always @(negedge clk) begin
    check_inst("n2", 0, 2, 0, iv0, int'(id0), ordy0, fl0, ov0, int'(od0), ir0, int'(cnt0), em0, fu0);
    check_inst("n4", 1, 4, 0, iv1, int'(id1), ordy1, fl1, ov1, int'(od1), ir1, int'(cnt1), em1, fu1);
    check_inst("n1", 2, 1, 165, iv2, int'(id2), ordy2, fl2, ov2, int'(od2), ir2, int'(cnt2), em2, fu2);
    if (reset && ov2 && ordy2) begin
      chk("n1_order", int'(od2), (rcv * 37 + 11) % 256);
      rcv++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, cyc;
    bit  acc;
    #1 reset = 1'b0;
    #1;
    chk("n1_rst_data_lit", int'(od2), 165);
    chk("n2_rst_valid_lit", int'(ov0), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("n2_idle_in_ready_lit", int'(ir0), 1);
    chk("n2_idle_empty_lit", int'(em0), 1);

    // Streaming N=2: 1,2,3 in, 1,2,3 out two edges later.
    ordy0 = 1'b1; iv0 = 1'b1; id0 = 3'd1;
    tick(); id0 = 3'd2;
    tick(); id0 = 3'd3; #1;
    chk("n2_stream_d1_lit", int'(od0), 1);
    chk("n2_stream_v1_lit", int'(ov0), 1);
    chk("n2_stream_cnt_lit", int'(cnt0), 2);
    tick(); iv0 = 1'b0; #1;
    chk("n2_stream_d2_lit", int'(od0), 2);
    chk("n2_stream_cnt2_lit", int'(cnt0), 2);
    tick(); #1;
    chk("n2_stream_d3_lit", int'(od0), 3);
    chk("n2_stream_cnt3_lit", int'(cnt0), 1);
    tick(); #1;
    chk("n2_stream_drained_lit", int'(em0), 1);
    ordy0 = 1'b0;

    // Reset mid-stream with two words inside.
    tick(); iv0 = 1'b1; id0 = 3'd5;
    tick(); id0 = 3'd6;
    tick(); iv0 = 1'b0; #1;
    chk("n2_pre_rst_cnt_lit", int'(cnt0), 2);
    chk("n2_pre_rst_data_lit", int'(od0), 5);
    #1 reset = 1'b0;
    #1;
    chk("n2_mid_rst_valid_lit", int'(ov0), 0);
    chk("n2_mid_rst_data_lit", int'(od0), 0);
    chk("n2_mid_rst_cnt_lit", int'(cnt0), 0);
    tick(); reset = 1'b1; #1;
    chk("n2_post_rst_empty_lit", int'(em0), 1);
    chk("n2_post_rst_in_ready_lit", int'(ir0), 1);

    // Backpressure N=4: five pushes with the consumer stalled.
    for (int i = 1; i <= 5; i++) begin
      tick(); iv1 = 1'b1; id1 = 3'(i);
    end
    tick(); #1;
    chk("n4_bp_full_lit", int'(fu1), 1);
    chk("n4_bp_in_ready_lit", int'(ir1), 0);
    chk("n4_bp_cnt_lit", int'(cnt1), 4);
    chk("n4_bp_head_lit", int'(od1), 1);
    ordy1 = 1'b1; #1;
    chk("n4_bp_pass_ready_lit", int'(ir1), 1);
    tick(); ordy1 = 1'b0; iv1 = 1'b0; #1;
    chk("n4_bp_swap_cnt_lit", int'(cnt1), 4);
    chk("n4_bp_swap_head_lit", int'(od1), 2);
    tick(); ordy1 = 1'b1;
    repeat (4) tick();
    #1;
    chk("n4_bp_drained_lit", int'(em1), 1);
    ordy1 = 1'b0;

    // Bubble collapse N=4: A, two idle cycles, B, consumer stalled.
    tick(); iv1 = 1'b1; id1 = 3'd6;
    tick(); iv1 = 1'b0;
    tick();
    tick(); iv1 = 1'b1; id1 = 3'd7;
    tick(); iv1 = 1'b0;
    repeat (2) tick();
    #1;
    chk("n4_bubble_cnt_lit", int'(cnt1), 2);
    chk("n4_bubble_in_ready_lit", int'(ir1), 1);
    chk("n4_bubble_head_lit", int'(od1), 6);

    // Flush with three words held and a word offered.
    tick(); iv1 = 1'b1; id1 = 3'd3;
    tick(); id1 = 3'd4; fl1 = 1'b1; #1;
    chk("n4_flush_cnt_lit", int'(cnt1), 3);
    chk("n4_flush_in_ready_lit", int'(ir1), 0);
    chk("n4_flush_out_valid_lit", int'(ov1), 0);
    tick(); fl1 = 1'b0; iv1 = 1'b0; #1;
    chk("n4_post_flush_cnt_lit", int'(cnt1), 0);
    chk("n4_post_flush_empty_lit", int'(em1), 1);
    ordy1 = 1'b1;
    repeat (4) tick();
    ordy1 = 1'b0;

    // N=1 stream of 100 words with a randomly stalling consumer.
    sent = 0; acc = 1'b0; cyc = 0;
    while (rcv < 100 && cyc < 3000) begin
      @(posedge clk);
      if (acc) sent++;
      #1;
      iv2   = (sent < 100);
      id2   = 8'((sent * 37 + 11) % 256);
      ordy2 = 1'($urandom_range(0, 1));
      #1 acc = iv2 && ir2;
      cyc++;
    end
    iv2 = 1'b0; ordy2 = 1'b0;
    chk("n1_received_lit", rcv, 100);

    // N=1 reset forcing with a word held.
    tick(); iv2 = 1'b1; id2 = 8'h3C;
    tick(); iv2 = 1'b0; #1;
    chk("n1_held_valid_lit", int'(ov2), 1);
    chk("n1_held_data_lit", int'(od2), 60);
    #1 reset = 1'b0;
    #1;
    chk("n1_rst_force_data_lit", int'(od2), 165);
    chk("n1_rst_force_valid_lit", int'(ov2), 0);
    chk("n1_rst_force_ready_lit", int'(ir2), 0);
    tick(); reset = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
